// File: rtl/msdap_pkg.sv
// Shared constants and state encoding for the MSDAP input-path sequencer.
package msdap_pkg;

    localparam int WORD_W          = 16;
    localparam int RJ_WORDS_DEF    = 16;
    localparam int COEF_WORDS_DEF  = 512;
    localparam int DATA_DEPTH_DEF  = 256;
    localparam int SLEEP_ZEROS_DEF = 800;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_WAIT_RJ   = 3'd1,
        ST_READ_RJ   = 3'd2,
        ST_READ_COEF = 3'd3,
        ST_WAIT_IN   = 3'd4,
        ST_WORKING   = 3'd5,
        ST_CLEARING  = 3'd6,
        ST_SLEEP     = 3'd7
    } state_e;

endpackage

// File: rtl/msdap_zero_run_det.sv
// Counts consecutive all-zero stereo samples; flags the sample that completes the run.
// Only compiled when MSDAP_SLEEP_EN is defined.
`ifdef MSDAP_SLEEP_EN
module msdap_zero_run_det
    import msdap_pkg::*;
#(
    parameter int SLEEP_ZEROS = SLEEP_ZEROS_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              vld_i,
    input  logic [WORD_W-1:0] data_L_i,
    input  logic [WORD_W-1:0] data_R_i,
    output logic              sleep_hit_o
);

    localparam int CW = $clog2(SLEEP_ZEROS + 1);
    localparam logic [CW-1:0] HIT = CW'(SLEEP_ZEROS - 1);
    localparam logic [CW-1:0] SAT = CW'(SLEEP_ZEROS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero;

    assign zero = (data_L_i == '0) && (data_R_i == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (vld_i)
            cnt_d = !zero ? '0 : ((cnt_q == SAT) ? SAT : cnt_q + 1'b1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // The current sample is the SLEEP_ZEROS-th zero when SLEEP_ZEROS-1 are already counted.
    assign sleep_hit_o = vld_i & zero & (cnt_q >= HIT);

endmodule
`endif

// File: rtl/msdap_main_ctrl.sv
// MSDAP input-path sequencer: routes words to Rj, coefficient and circular data memory.
// Define MSDAP_SLEEP_EN to enable the zero-run detector and the SLEEP state.
module msdap_main_ctrl
    import msdap_pkg::*;
#(
    parameter int RJ_WORDS    = RJ_WORDS_DEF,
    parameter int COEF_WORDS  = COEF_WORDS_DEF,
    parameter int DATA_DEPTH  = DATA_DEPTH_DEF
`ifdef MSDAP_SLEEP_EN
  , parameter int SLEEP_ZEROS = SLEEP_ZEROS_DEF
`endif
) (
    input  logic                          Dclk,
    input  logic                          clear_n,
    input  logic                          input_ready,
    input  logic [WORD_W-1:0]             data_L,
    input  logic [WORD_W-1:0]             data_R,
    input  logic                          reset_req,
    input  logic                          compute_busy,
    output logic [2:0]                    state,
    output logic                          rj_we,
    output logic [$clog2(RJ_WORDS)-1:0]   rj_addr,
    output logic                          coef_we,
    output logic [$clog2(COEF_WORDS)-1:0] coef_addr,
    output logic                          dm_we,
    output logic [$clog2(DATA_DEPTH)-1:0] dm_addr,
    output logic [WORD_W-1:0]             wdata_L,
    output logic [WORD_W-1:0]             wdata_R,
    output logic                          compute_start,
    output logic                          sleep_flag,
    output logic                          overrun
);

    localparam int RA = $clog2(RJ_WORDS);
    localparam int CA = $clog2(COEF_WORDS);
    localparam int DA = $clog2(DATA_DEPTH);
    localparam logic [CA-1:0] RJ_LAST   = CA'(RJ_WORDS - 1);
    localparam logic [CA-1:0] COEF_LAST = CA'(COEF_WORDS - 1);
    localparam logic [DA-1:0] DA_LAST   = DA'(DATA_DEPTH - 1);

    state_e              state_q, state_d;
    logic                ir_q;
    logic [DA-1:0]       clr_cnt_q, clr_cnt_d;
    logic [CA-1:0]       wcnt_q, wcnt_d;
    logic [DA-1:0]       wptr_q, wptr_d;
    logic                rj_we_q, rj_we_d;
    logic [RA-1:0]       rj_addr_q, rj_addr_d;
    logic                coef_we_q, coef_we_d;
    logic [CA-1:0]       coef_addr_q, coef_addr_d;
    logic                dm_we_q, dm_we_d;
    logic [DA-1:0]       dm_addr_q, dm_addr_d;
    logic [WORD_W-1:0]   wdata_L_q, wdata_L_d, wdata_R_q, wdata_R_d;
    logic                cs_pend_q, cs_pend_d;
    logic                compute_start_q;
    logic                overrun_q, overrun_d;

    logic ev, is_zero, flush, sleep_hit;

    assign ev      = input_ready & ~ir_q;
    assign is_zero = (data_L == '0) && (data_R == '0);
    assign flush   = reset_req &
                     ((state_q == ST_WAIT_IN) || (state_q == ST_WORKING) || (state_q == ST_SLEEP));

`ifdef MSDAP_SLEEP_EN
    logic smp_vld;
    assign smp_vld = ev & (state_q == ST_WORKING) & ~reset_req;

    msdap_zero_run_det #(.SLEEP_ZEROS(SLEEP_ZEROS)) u_zero_run (
        .clk_i       (Dclk),
        .rst_ni      (clear_n),
        .clear_i     (state_q != ST_WORKING),
        .vld_i       (smp_vld),
        .data_L_i    (data_L),
        .data_R_i    (data_R),
        .sleep_hit_o (sleep_hit)
    );
    assign sleep_flag = (state_q == ST_SLEEP);
`else
    assign sleep_hit  = 1'b0;
    assign sleep_flag = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wcnt_d      = wcnt_q;
        wptr_d      = wptr_q;
        rj_we_d     = 1'b0;
        rj_addr_d   = rj_addr_q;
        coef_we_d   = 1'b0;
        coef_addr_d = coef_addr_q;
        dm_we_d     = 1'b0;
        dm_addr_d   = dm_addr_q;
        wdata_L_d   = wdata_L_q;
        wdata_R_d   = wdata_R_q;
        cs_pend_d   = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_INIT, ST_CLEARING: begin
                // Sweep the whole data memory with zeros; any word arriving now is lost.
                dm_we_d   = 1'b1;
                dm_addr_d = clr_cnt_q;
                wdata_L_d = '0;
                wdata_R_d = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                overrun_d = ev;
                if (clr_cnt_q == DA_LAST) begin
                    state_d   = (state_q == ST_INIT) ? ST_WAIT_RJ : ST_WAIT_IN;
                    clr_cnt_d = '0;
                    wptr_d    = '0;
                end
            end
            ST_WAIT_RJ, ST_READ_RJ: begin
                if (ev) begin
                    rj_we_d   = 1'b1;
                    rj_addr_d = wcnt_q[RA-1:0];
                    wdata_L_d = data_L;
                    wdata_R_d = data_R;
                    wcnt_d    = wcnt_q + 1'b1;
                    state_d   = ST_READ_RJ;
                    if (wcnt_q == RJ_LAST) begin
                        state_d = ST_READ_COEF;
                        wcnt_d  = '0;
                    end
                end
            end
            ST_READ_COEF: begin
                if (ev) begin
                    coef_we_d   = 1'b1;
                    coef_addr_d = wcnt_q;
                    wdata_L_d   = data_L;
                    wdata_R_d   = data_R;
                    wcnt_d      = wcnt_q + 1'b1;
                    if (wcnt_q == COEF_LAST) begin
                        state_d = ST_WAIT_IN;
                        wcnt_d  = '0;
                    end
                end
            end
            default: begin
                // WAIT_IN, WORKING, SLEEP
                if (flush) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = '0;
                end else if (ev && ((state_q != ST_SLEEP) || !is_zero)) begin
                    dm_we_d   = 1'b1;
                    dm_addr_d = wptr_q;
                    wptr_d    = wptr_q + 1'b1;
                    wdata_L_d = data_L;
                    wdata_R_d = data_R;
                    cs_pend_d = ~compute_busy;
                    overrun_d = compute_busy;
                    state_d   = sleep_hit ? ST_SLEEP : ST_WORKING;
                end
            end
        endcase
    end

    always_ff @(posedge Dclk or negedge clear_n) begin
        if (!clear_n) begin
            state_q         <= ST_INIT;
            ir_q            <= 1'b0;
            clr_cnt_q       <= '0;
            wcnt_q          <= '0;
            wptr_q          <= '0;
            rj_we_q         <= 1'b0;
            rj_addr_q       <= '0;
            coef_we_q       <= 1'b0;
            coef_addr_q     <= '0;
            dm_we_q         <= 1'b0;
            dm_addr_q       <= '0;
            wdata_L_q       <= '0;
            wdata_R_q       <= '0;
            cs_pend_q       <= 1'b0;
            compute_start_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            ir_q            <= input_ready;
            clr_cnt_q       <= clr_cnt_d;
            wcnt_q          <= wcnt_d;
            wptr_q          <= wptr_d;
            rj_we_q         <= rj_we_d;
            rj_addr_q       <= rj_addr_d;
            coef_we_q       <= coef_we_d;
            coef_addr_q     <= coef_addr_d;
            dm_we_q         <= dm_we_d;
            dm_addr_q       <= dm_addr_d;
            wdata_L_q       <= wdata_L_d;
            wdata_R_q       <= wdata_R_d;
            cs_pend_q       <= cs_pend_d;
            compute_start_q <= cs_pend_q;
            overrun_q       <= overrun_d;
        end
    end

    assign state         = state_q;
    assign rj_we         = rj_we_q;
    assign rj_addr       = rj_addr_q;
    assign coef_we       = coef_we_q;
    assign coef_addr     = coef_addr_q;
    assign dm_we         = dm_we_q;
    assign dm_addr       = dm_addr_q;
    assign wdata_L       = wdata_L_q;
    assign wdata_R       = wdata_R_q;
    assign compute_start = compute_start_q;
    assign overrun       = overrun_q;

endmodule
